// File: rtl/tcm_dport_adapter.sv
// 32-bit LSU request/response adapter in front of one 64-bit TCM RAM port.
// Decodes the TCM window, steers byte lanes and queues responses in a 2-entry FIFO.
module tcm_dport_adapter #(
    parameter int unsigned TCM_MEM_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int unsigned TAG_W         = 4,
    localparam int unsigned AW           = $clog2(TCM_MEM_DEPTH*1024/8)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_accept_o,
    input  logic [31:0]      req_addr_i,
    input  logic [3:0]       req_wr_i,
    input  logic [31:0]      req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_error_o,
    output logic [AW-1:0]    ram_addr_o,
    output logic [63:0]      ram_data_o,
    output logic [7:0]       ram_wr_o,
    input  logic [63:0]      ram_data_i
);

    localparam logic [31:0] TCM_BYTES = 32'(TCM_MEM_DEPTH*1024);

    logic [31:0]      off_p0;
    logic             in_range_p0;
    logic             fire_p0;

    logic             vld_p1;
    logic             sel_p1;
    logic             wr_p1;
    logic             err_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [1:0]       cnt;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             push;
    logic             pop;
    logic [31:0]      push_data;
    logic [31:0]      fifo_data [2];
    logic [TAG_W-1:0] fifo_tag  [2];
    logic             fifo_err  [2];

    // Stage P0: decode and RAM request; subtraction wraps so addresses below the base fall out of range
    assign off_p0      = req_addr_i - BASE_ADDR;
    assign in_range_p0 = off_p0 < TCM_BYTES;

    assign pop          = resp_valid_o & resp_ready_i;
    assign push         = vld_p1;
    // A slot is free if fewer than two are outstanding, or the head leaves this same cycle
    assign req_accept_o = rst_i & ((({1'b0, cnt} + {2'b00, vld_p1}) < 3'd2) | pop);
    assign fire_p0      = req_valid_i & req_accept_o;

    assign ram_addr_o = off_p0[AW+2:3];
    assign ram_data_o = {req_data_i, req_data_i};
    assign ram_wr_o   = (fire_p0 & in_range_p0) ?
                        (off_p0[2] ? {req_wr_i, 4'b0000} : {4'b0000, req_wr_i}) : 8'h00;

    // Stage P1: request attributes waiting for RAM read data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= fire_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire_p0) begin
            sel_p1 <= off_p0[2];
            wr_p1  <= |req_wr_i;
            err_p1 <= ~in_range_p0;
            tag_p1 <= req_tag_i;
        end
    end

    assign push_data = (wr_p1 | err_p1) ? 32'h0 :
                       (sel_p1 ? ram_data_i[63:32] : ram_data_i[31:0]);

    // Stage P2: in-order response FIFO
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_tag[wr_ptr]  <= tag_p1;
            fifo_err[wr_ptr]  <= err_p1;
        end
    end

    assign resp_valid_o = (cnt != 2'd0);
    assign resp_data_o  = fifo_data[rd_ptr];
    assign resp_tag_o   = fifo_tag[rd_ptr];
    assign resp_error_o = fifo_err[rd_ptr];

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(push && !pop && cnt == 2'd2));

endmodule

// File: tb/tb_tcm_dport_adapter.sv
// Bench for tcm_dport_adapter: vector table plus corner sequences, checked by a response scoreboard.
module tb_tcm_dport_adapter;

    localparam int unsigned TCM_MEM_DEPTH = 32;
    localparam logic [31:0] BASE          = 32'h0002_0000;
    localparam int unsigned TAG_W         = 4;
    localparam int unsigned AW            = 12;
    localparam logic [31:0] TCM_BYTES     = 32'h0000_8000;

    logic             clk_i;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_accept_o;
    logic [31:0]      req_addr_i;
    logic [3:0]       req_wr_i;
    logic [31:0]      req_data_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [31:0]      resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             resp_error_o;
    logic [AW-1:0]    ram_addr_o;
    logic [63:0]      ram_data_o;
    logic [7:0]       ram_wr_o;
    logic [63:0]      ram_data_i;

    tcm_dport_adapter #(
        .TCM_MEM_DEPTH(TCM_MEM_DEPTH),
        .BASE_ADDR    (BASE),
        .TAG_W        (TAG_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_accept_o(req_accept_o),
        .req_addr_i  (req_addr_i),
        .req_wr_i    (req_wr_i),
        .req_data_i  (req_data_i),
        .req_tag_i   (req_tag_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_data_o (resp_data_o),
        .resp_tag_o  (resp_tag_o),
        .resp_error_o(resp_error_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_wr_o    (ram_wr_o),
        .ram_data_i  (ram_data_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Downstream RAM: byte-enabled write, registered read one cycle after the address
    logic [63:0] ram [0:4095];
    logic        ram_clr = 1'b1;
    always @(posedge clk_i) begin
        if (ram_clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 64'h0;
            ram_clr <= 1'b0;
        end else begin
            for (int b = 0; b < 8; b++)
                if (ram_wr_o[b]) ram[ram_addr_o][b*8 +: 8] <= ram_data_o[b*8 +: 8];
        end
        ram_data_i <= ram[ram_addr_o];
    end

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             err;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       wr;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [7:0]       exp_wr;
    } vec_t;

    exp_t        sbq[$];
    logic [63:0] ref_mem [0:4095];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: drive at negedge, sample just before the next posedge
    task automatic cycle(input logic rst, input logic v, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input logic [TAG_W-1:0] t, input logic rdy,
                         output logic fired, output logic [7:0] act_wr);
        logic [31:0] off;
        logic        inr;
        logic [7:0]  ewr;
        logic [63:0] word;
        exp_t        e;
        @(negedge clk_i);
        rst_i = rst; req_valid_i = v; req_addr_i = a; req_wr_i = w;
        req_data_i = d; req_tag_i = t; resp_ready_i = rdy;
        #3;
        fired  = v & req_accept_o;
        act_wr = ram_wr_o;
        off    = a - BASE;
        inr    = off < TCM_BYTES;
        ewr    = 8'h00;
        if (fired && inr) ewr = off[2] ? {w, 4'b0000} : {4'b0000, w};
        check("ram_wr", {56'h0, ram_wr_o}, {56'h0, ewr});
        if (!rst) check("accept_in_reset", {63'h0, req_accept_o}, 64'h0);
        if (rst && resp_valid_o === 1'b1 && rdy) begin
            n_pop++;
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got tag %0h expected no response", resp_tag_o);
            end else begin
                e = sbq.pop_front();
                check("resp_tag", {60'h0, resp_tag_o}, {60'h0, e.tag});
                check("resp_data", {32'h0, resp_data_o}, {32'h0, e.data});
                check("resp_err", {63'h0, resp_error_o}, {63'h0, e.err});
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        if (fired) begin
            word  = ref_mem[off[AW+2:3]];
            e.tag = t; e.err = ~inr; e.cyc = cyc;
            e.data = (w != 4'h0 || !inr) ? 32'h0 : (off[2] ? word[63:32] : word[31:0]);
            if (w != 4'h0 && inr) begin
                for (int b = 0; b < 4; b++)
                    if (w[b]) word[(off[2] ? 32 : 0) + b*8 +: 8] = d[b*8 +: 8];
                ref_mem[off[AW+2:3]] = word;
            end
            sbq.push_back(e);
        end
        if (!rst) sbq.delete();
        cyc++;
        @(posedge clk_i);
    endtask

    task automatic drain(input int max_cyc);
        logic       f;
        logic [7:0] aw;
        int         k;
        k = 0;
        while (sbq.size() != 0 && k < max_cyc) begin
            cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, '0, 1'b1, f, aw);
            k++;
        end
        check("drain_empty", 64'(sbq.size()), 64'h0);
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, '0, 1'b1, f, aw);
        #1;
        check("idle_resp_valid", {63'h0, resp_valid_o}, 64'h0);
    endtask

    vec_t       vt[12];
    logic       f;
    logic [7:0] aw;
    int         p0;

    initial begin
        vt[0]  = '{BASE + 32'h4,    4'hF,    32'hDEADBEEF, 4'd1,  8'hF0};
        vt[1]  = '{BASE + 32'h4,    4'h0,    32'h0,        4'd2,  8'h00};
        vt[2]  = '{BASE + 32'h0,    4'b0010, 32'h0000AB00, 4'd3,  8'h02};
        vt[3]  = '{BASE + 32'h0,    4'h0,    32'h0,        4'd4,  8'h00};
        vt[4]  = '{BASE + TCM_BYTES, 4'h0,   32'h0,        4'd5,  8'h00};
        vt[5]  = '{BASE + TCM_BYTES, 4'hF,   32'h12345678, 4'd6,  8'h00};
        vt[6]  = '{BASE + 32'h0,    4'h0,    32'h0,        4'd7,  8'h00};
        vt[7]  = '{BASE + 32'h7FFC, 4'b1000, 32'hAA000000, 4'd8,  8'h80};
        vt[8]  = '{BASE + 32'h7FFC, 4'h0,    32'h0,        4'd9,  8'h00};
        vt[9]  = '{BASE - 32'h4,    4'h0,    32'h0,        4'd10, 8'h00};
        vt[10] = '{BASE + 32'h8,    4'b0001, 32'h00000011, 4'd11, 8'h01};
        vt[11] = '{BASE + 32'h8,    4'h0,    32'h0,        4'd12, 8'h00};
        for (int i = 0; i < 4096; i++) ref_mem[i] = 64'h0;

        rst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0; req_wr_i = 4'h0;
        req_data_i = 32'h0; req_tag_i = '0; resp_ready_i = 1'b0;

        // Reset: requests (even writes) must be refused and nothing reported
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, BASE, 4'hF, 32'h1, '0, 1'b1, f, aw);
        #1;
        check("reset_resp_valid", {63'h0, resp_valid_o}, 64'h0);

        // Vector table, consumer always ready
        for (int i = 0; i < 12; i++) begin
            int k;
            k = 0;
            f = 1'b0;
            while (!f && k < 8) begin
                cycle(1'b1, 1'b1, vt[i].addr, vt[i].wr, vt[i].data, vt[i].tag, 1'b1, f, aw);
                k++;
            end
            check("vec_fire", {63'h0, f}, 64'h1);
            check("vec_ram_wr", {56'h0, aw}, {56'h0, vt[i].exp_wr});
        end
        drain(10);

        // Backpressure: two reads accepted, third held until the first pop
        cycle(1'b1, 1'b1, BASE + 32'h4, 4'h0, 32'h0, 4'd0, 1'b0, f, aw);
        check("bp_fire0", {63'h0, f}, 64'h1);
        cycle(1'b1, 1'b1, BASE + 32'h0, 4'h0, 32'h0, 4'd1, 1'b0, f, aw);
        check("bp_fire1", {63'h0, f}, 64'h1);
        cycle(1'b1, 1'b1, BASE + 32'h8, 4'h0, 32'h0, 4'd2, 1'b0, f, aw);
        check("bp_hold_a", {63'h0, f}, 64'h0);
        cycle(1'b1, 1'b1, BASE + 32'h8, 4'h0, 32'h0, 4'd2, 1'b0, f, aw);
        check("bp_hold_b", {63'h0, f}, 64'h0);
        p0 = n_pop;
        cycle(1'b1, 1'b1, BASE + 32'h8, 4'h0, 32'h0, 4'd2, 1'b1, f, aw);
        check("bp_fire2", {63'h0, f}, 64'h1);
        check("bp_pop_same_cycle", 64'(n_pop - p0), 64'h1);
        drain(10);

        // Streaming: one read per cycle at fixed 2-cycle latency
        lat_chk = 1'b1;
        for (int t = 0; t < 8; t++) begin
            cycle(1'b1, 1'b1, BASE + 32'(4*t), 4'h0, 32'h0, TAG_W'(t), 1'b1, f, aw);
            check("stream_fire", {63'h0, f}, 64'h1);
        end
        drain(10);
        lat_chk = 1'b0;

        // Reset with traffic in flight: everything is dropped
        cycle(1'b1, 1'b1, BASE + 32'h4, 4'h0, 32'h0, 4'd3, 1'b0, f, aw);
        cycle(1'b1, 1'b1, BASE + 32'h0, 4'h0, 32'h0, 4'd4, 1'b0, f, aw);
        cycle(1'b0, 1'b1, BASE + 32'h4, 4'hF, 32'hFFFFFFFF, 4'd5, 1'b0, f, aw);
        #1;
        check("rst_flush_valid", {63'h0, resp_valid_o}, 64'h0);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, '0, 1'b0, f, aw);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, '0, 1'b1, f, aw);
        cycle(1'b1, 1'b1, BASE + 32'h4, 4'h0, 32'h0, 4'd9, 1'b1, f, aw);
        check("post_rst_fire", {63'h0, f}, 64'h1);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
